// File: rtl/axi_w_master_pkg.sv
// Shared definitions for the AXI4 write-channel master.
// Contents: default AXI widths, BURST_* and RESP_* encodings, the
// write-master state type and the size-to-byte-mask helper.
package axi_w_master_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wstate_e;

  // Byte-lane mask for an access of 2**size bytes starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/axi_w_align.sv
// Combinational store aligner: moves LSB-aligned write data to its byte
// lane within the bus word and builds the matching byte strobe.
// Lanes pushed past the top of the word are dropped (no split access).
// Ports:
//   size     in  access size code (00:1B 01:2B 10:4B 11:8B)
//   offset   in  byte offset within the bus word
//   data_in  in  LSB-aligned store data
//   data_out out lane-aligned data
//   strb     out byte strobe
module axi_w_align
  import axi_w_master_pkg::*;
#(
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic [1:0]          size,
  input  logic [2:0]          offset,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic [DATA_W/8-1:0] strb
);

  localparam int unsigned STRB_W = DATA_W / 8;

  always_comb begin
    data_out = data_in << {offset, 3'b000};
    strb     = STRB_W'(size_mask(size)) << offset;
  end

endmodule

// File: rtl/axi_w_master.sv
// AXI4 write-channel master. Accepts one write request from the LSU /
// D-cache side, issues AW, streams the W beats (aligned, with strobes) and
// returns the B response as a one-cycle pulse.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_aw_*, cpu_id/addr/len/size   request side (accepted in IDLE)
//   cpu_w_*               beat stream, LSB-aligned data
//   cpu_b_valid/resp      response pulse and held BRESP
//   axi_aw_*, axi_w_*, axi_b_*       AXI4 write address/data/response
// Build option: define YSYX_22041071_AXI_W_IDCHK_EN to check BID against
// the issued AWID and force SLVERR on mismatch.
module axi_w_master
  import axi_w_master_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_ID_W,
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned LEN_W  = AXI_LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_aw_valid,
  output logic                cpu_aw_ready,
  input  logic [ID_W-1:0]     cpu_id,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [LEN_W-1:0]    cpu_len,
  input  logic [1:0]          cpu_size,
  input  logic                cpu_w_valid,
  output logic                cpu_w_ready,
  input  logic [DATA_W-1:0]   cpu_w_data,
  output logic                cpu_b_valid,
  output logic [1:0]          cpu_b_resp,
  output logic                axi_aw_valid_o,
  input  logic                axi_aw_ready_i,
  output logic [ID_W-1:0]     axi_aw_id_o,
  output logic [ADDR_W-1:0]   axi_aw_addr_o,
  output logic [LEN_W-1:0]    axi_aw_len_o,
  output logic [2:0]          axi_aw_size_o,
  output logic [1:0]          axi_aw_burst_o,
  output logic [2:0]          axi_aw_prot_o,
  output logic [3:0]          axi_aw_cache_o,
  output logic                axi_aw_lock_o,
  output logic [3:0]          axi_aw_qos_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  output logic [DATA_W-1:0]   axi_w_data_o,
  output logic [DATA_W/8-1:0] axi_w_strb_o,
  output logic                axi_w_last_o,
  input  logic                axi_b_valid_i,
  output logic                axi_b_ready_o,
  input  logic [1:0]          axi_b_resp_i,
  input  logic [ID_W-1:0]     axi_b_id_i
);

  wstate_e state, state_nx;

  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [1:0]          size_q;
  logic [LEN_W-1:0]    beat_cnt;
  logic                aw_done;
  logic                w_done;

  logic                in_write;
  logic                accept;
  logic                aw_hs;
  logic                w_hs;
  logic                last_hs;
  logic                write_done;
  logic                b_hs;
  logic [1:0]          resp_nx;
  logic [DATA_W-1:0]   aligned_data;
  logic [DATA_W/8-1:0] aligned_strb;

  // Handshakes are derived from state and inputs directly rather than from
  // the output ports, keeping the next-state logic free of feedback.
  assign in_write   = (state == ST_WRITE);
  assign accept     = (state == ST_IDLE) && cpu_aw_valid;
  assign aw_hs      = in_write && !aw_done && axi_aw_ready_i;
  assign w_hs       = in_write && !w_done && cpu_w_valid && axi_w_ready_i;
  assign last_hs    = w_hs && (beat_cnt == len_q);
  // AW and the last W beat may finish in either order or together.
  assign write_done = in_write && (aw_done || aw_hs) && (w_done || last_hs);
  assign b_hs       = (state == ST_RESP) && axi_b_valid_i;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    cpu_aw_ready   = 1'b0;
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    cpu_w_ready    = 1'b0;
    axi_b_ready_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_aw_ready = 1'b1;
        if (cpu_aw_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        axi_aw_valid_o = !aw_done;
        axi_w_valid_o  = cpu_w_valid && !w_done;
        cpu_w_ready    = axi_w_ready_i && !w_done;
        if (write_done) state_nx = ST_RESP;
      end
      ST_RESP: begin
        axi_b_ready_o = 1'b1;
        if (axi_b_valid_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      beat_cnt    <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cpu_b_valid <= 1'b0;
      cpu_b_resp  <= '0;
    end else begin
      cpu_b_valid <= 1'b0;
      if (accept) begin
        id_q     <= cpu_id;
        addr_q   <= cpu_addr;
        len_q    <= cpu_len;
        size_q   <= cpu_size;
        beat_cnt <= '0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else if (write_done) begin
        beat_cnt <= '0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
          if (last_hs) w_done <= 1'b1;
        end
      end
      if (b_hs) begin
        cpu_b_valid <= 1'b1;
        cpu_b_resp  <= resp_nx;
      end
    end
  end

`ifdef YSYX_22041071_AXI_W_IDCHK_EN
  logic id_mismatch;
  assign id_mismatch = (axi_b_id_i != id_q);
  assign resp_nx     = id_mismatch ? RESP_SLVERR : axi_b_resp_i;
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && b_hs && id_mismatch)
      $error("axi_w_master: BID %0h does not match AWID %0h", axi_b_id_i, id_q);
  end
`endif
`else
  logic unused_bid;
  assign unused_bid = ^axi_b_id_i;
  assign resp_nx    = axi_b_resp_i;
`endif

  axi_w_align #(.DATA_W(DATA_W)) u_align (
    .size     (size_q),
    .offset   (addr_q[2:0]),
    .data_in  (cpu_w_data),
    .data_out (aligned_data),
    .strb     (aligned_strb)
  );

  // AW fields come straight from the request registers, so they stay stable
  // for as long as AW valid is held.
  assign axi_aw_id_o    = id_q;
  assign axi_aw_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign axi_aw_len_o   = len_q;
  assign axi_aw_size_o  = {1'b0, size_q};
  assign axi_aw_burst_o = in_write ? BURST_INCR : BURST_FIXED;
  assign axi_aw_prot_o  = '0;
  assign axi_aw_cache_o = '0;
  assign axi_aw_lock_o  = 1'b0;
  assign axi_aw_qos_o   = '0;

  assign axi_w_data_o   = in_write ? aligned_data : '0;
  assign axi_w_strb_o   = in_write ? aligned_strb : '0;
  assign axi_w_last_o   = in_write && (beat_cnt == len_q);

endmodule

// File: tb/tb_axi_w_master.sv
module tb_axi_w_master;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_aw_valid;
  logic              cpu_aw_ready;
  logic [ID_W-1:0]   cpu_id;
  logic [ADDR_W-1:0] cpu_addr;
  logic [LEN_W-1:0]  cpu_len;
  logic [1:0]        cpu_size;
  logic              cpu_w_valid;
  logic              cpu_w_ready;
  logic [DATA_W-1:0] cpu_w_data;
  logic              cpu_b_valid;
  logic [1:0]        cpu_b_resp;
  logic              axi_aw_valid_o;
  logic              axi_aw_ready_i;
  logic [ID_W-1:0]   axi_aw_id_o;
  logic [ADDR_W-1:0] axi_aw_addr_o;
  logic [LEN_W-1:0]  axi_aw_len_o;
  logic [2:0]        axi_aw_size_o;
  logic [1:0]        axi_aw_burst_o;
  logic [2:0]        axi_aw_prot_o;
  logic [3:0]        axi_aw_cache_o;
  logic              axi_aw_lock_o;
  logic [3:0]        axi_aw_qos_o;
  logic              axi_w_valid_o;
  logic              axi_w_ready_i;
  logic [DATA_W-1:0] axi_w_data_o;
  logic [7:0]        axi_w_strb_o;
  logic              axi_w_last_o;
  logic              axi_b_valid_i;
  logic              axi_b_ready_o;
  logic [1:0]        axi_b_resp_i;
  logic [ID_W-1:0]   axi_b_id_i;

  axi_w_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_aw_valid(cpu_aw_valid), .cpu_aw_ready(cpu_aw_ready), .cpu_id(cpu_id),
    .cpu_addr(cpu_addr), .cpu_len(cpu_len), .cpu_size(cpu_size),
    .cpu_w_valid(cpu_w_valid), .cpu_w_ready(cpu_w_ready), .cpu_w_data(cpu_w_data),
    .cpu_b_valid(cpu_b_valid), .cpu_b_resp(cpu_b_resp),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_cache_o(axi_aw_cache_o),
    .axi_aw_lock_o(axi_aw_lock_o), .axi_aw_qos_o(axi_aw_qos_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] cap_aw_addr;
  logic [63:0] cap_w_data;
  logic [7:0]  cap_w_strb;
  logic        cap_w_last;
  int          cap_beats_at_aw;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte count is 2**size, lanes start at addr%8, and
  // anything past lane 7 is simply lost.
  function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] s);
    int unsigned nbytes;
    int unsigned off;
    logic [15:0] m;
    nbytes = 1 << s;
    off    = int'(a % 64'd8);
    m      = 16'((1 << nbytes) - 1);
    m      = m << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_data(input logic [63:0] d, input logic [63:0] a);
    logic [127:0] w;
    w = {64'b0, d} << ((a % 64'd8) * 8);
    return w[63:0];
  endfunction

  function automatic logic [1:0] m_resp(input logic [3:0] id, input logic [3:0] bid,
                                        input logic [1:0] bresp);
`ifdef YSYX_22041071_AXI_W_IDCHK_EN
    return (bid != id) ? 2'b10 : bresp;
`else
    return bresp;
`endif
  endfunction

  // Acts as both requester and AXI slave for one transaction, checking every
  // cycle against the protocol model. Starts and ends just after a posedge.
  task automatic run_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] size, input logic [63:0] d0, input int aw_delay,
                         input int wmode, input logic [1:0] bresp, input logic [3:0] bid);
    logic [63:0] beats[$];
    int nb, wk, done_cyc, bdelay;
    bit aw_seen, last_seen, b_seen, aw_now, last_now, timed_out;
    logic [1:0] exp_resp;
    nb = int'(len) + 1;
    beats.push_back(d0);
    for (int i = 1; i < nb; i++) beats.push_back({$urandom, $urandom});
    exp_resp  = m_resp(id, bid, bresp);
    bdelay    = int'($urandom_range(0, 3));
    aw_seen   = 0; last_seen = 0; b_seen = 0; wk = 0; done_cyc = 0; timed_out = 1;

    cpu_aw_valid = 1'b1; cpu_id = id; cpu_addr = addr; cpu_len = len; cpu_size = size;
    #4;
    chk("req_aw_ready", 64'(cpu_aw_ready), 64'd1);
    chk("aw_valid_at_accept", 64'(axi_aw_valid_o), 64'd0);
    step();
    // Scramble request inputs to prove the DUT latched them.
    cpu_aw_valid = 1'b0; cpu_id = 4'($urandom); cpu_addr = {$urandom, $urandom};
    cpu_len = 8'($urandom); cpu_size = 2'($urandom);

    for (int cyc = 0; cyc < 300; cyc++) begin
      axi_aw_ready_i = (cyc >= aw_delay);
      case (wmode)
        0:       axi_w_ready_i = 1'b1;
        1:       axi_w_ready_i = (cyc % 2 == 0);
        default: axi_w_ready_i = 1'($urandom_range(0, 1));
      endcase
      cpu_w_valid   = (wk < nb) && (wmode != 2 || $urandom_range(0, 3) != 0);
      cpu_w_data    = (wk < nb) ? beats[wk] : {$urandom, $urandom};
      axi_b_valid_i = aw_seen && last_seen && (cyc >= done_cyc + bdelay);
      axi_b_resp_i  = bresp;
      axi_b_id_i    = bid;
      #4;
      chk("aw_ready_busy", 64'(cpu_aw_ready), 64'd0);
      chk("b_ready", 64'(axi_b_ready_o), 64'(aw_seen && last_seen));
      chk("aw_valid", 64'(axi_aw_valid_o), 64'(!aw_seen));
      chk("b_valid_early", 64'(cpu_b_valid), 64'd0);
      aw_now = axi_aw_valid_o && axi_aw_ready_i;
      if (aw_now) begin
        chk("aw_addr", axi_aw_addr_o, addr & ~64'h7);
        chk("aw_len", 64'(axi_aw_len_o), 64'(len));
        chk("aw_size", 64'(axi_aw_size_o), 64'(size));
        chk("aw_burst", 64'(axi_aw_burst_o), 64'd1);
        chk("aw_id", 64'(axi_aw_id_o), 64'(id));
        chk("aw_attr", 64'({axi_aw_prot_o, axi_aw_cache_o, axi_aw_lock_o, axi_aw_qos_o}), 64'd0);
        cap_aw_addr     = axi_aw_addr_o;
        cap_beats_at_aw = wk;
      end
      if (!last_seen) begin
        chk("w_valid", 64'(axi_w_valid_o), 64'(cpu_w_valid));
        chk("w_ready", 64'(cpu_w_ready), 64'(axi_w_ready_i));
      end
      last_now = 0;
      if (axi_w_valid_o && axi_w_ready_i) begin
        chk("w_data", axi_w_data_o, m_data(beats[wk], addr));
        chk("w_strb", 64'(axi_w_strb_o), 64'(m_strb(addr, size)));
        chk("w_last", 64'(axi_w_last_o), 64'(wk == nb - 1));
        cap_w_data = axi_w_data_o; cap_w_strb = axi_w_strb_o; cap_w_last = axi_w_last_o;
        wk++;
        last_now = (wk == nb);
      end
      if (axi_b_valid_i && axi_b_ready_o) b_seen = 1;
      if (aw_now) aw_seen = 1;
      if (last_now) last_seen = 1;
      if ((aw_now || last_now) && aw_seen && last_seen) done_cyc = cyc + 1;
      step();
      if (b_seen) begin
        timed_out = 0;
        break;
      end
    end
    axi_b_valid_i = 1'b0; axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; cpu_w_valid = 1'b0;
    if (timed_out) begin
      n_cmp++; n_err++;
      $display("FAIL txn_timeout: got no B handshake, required one within 300 cycles");
    end else begin
      #4;
      chk("b_pulse", 64'(cpu_b_valid), 64'd1);
      chk("b_resp", 64'(cpu_b_resp), 64'(exp_resp));
      chk("idle_after_b", 64'(cpu_aw_ready), 64'd1);
      step();
      #4;
      chk("b_pulse_end", 64'(cpu_b_valid), 64'd0);
      chk("b_resp_hold", 64'(cpu_b_resp), 64'(exp_resp));
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  r_len;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [3:0]  r_id, r_bid;

    vecs[0] = '{64'h8000_0003, 2'd0, 64'hAB,                  64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000};
    vecs[1] = '{64'h8000_0004, 2'd2, 64'hDEAD_BEEF,           64'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[2] = '{64'h0000_1006, 2'd2, 64'h1122_3344,           64'h0000_1000, 8'hC0, 64'h3344_0000_0000_0000};
    vecs[3] = '{64'h0000_2007, 2'd3, 64'h0102_0304_0506_0708, 64'h0000_2000, 8'h80, 64'h0800_0000_0000_0000};
    vecs[4] = '{64'h0000_3010, 2'd1, 64'hBEEF,                64'h0000_3010, 8'h03, 64'h0000_0000_0000_BEEF};
    vecs[5] = '{64'hFFFF_FFFF_0000_1005, 2'd1, 64'hCAFE,      64'hFFFF_FFFF_0000_1000, 8'h60, 64'h00CA_FE00_0000_0000};
    vecs[6] = '{64'h0000_0008, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h0000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF};

    reset = 1'b1; cpu_aw_valid = 1'b0; cpu_id = '0; cpu_addr = '0; cpu_len = '0; cpu_size = '0;
    cpu_w_valid = 1'b0; cpu_w_data = '0; axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0;
    axi_b_valid_i = 1'b0; axi_b_resp_i = '0; axi_b_id_i = '0;
    step(); step(); step();
    #4;
    chk("rst_aw_ready", 64'(cpu_aw_ready), 64'd1);
    chk("rst_valids", 64'({axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o, cpu_w_ready, cpu_b_valid}), 64'd0);
    chk("rst_b_resp", 64'(cpu_b_resp), 64'd0);
    chk("rst_w_out", 64'({axi_w_strb_o, axi_w_last_o}) | axi_w_data_o, 64'd0);
    chk("rst_aw_out", axi_aw_addr_o | 64'({axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o}), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Single-beat alignment table.
    for (int i = 0; i < 7; i++) begin
      run_txn(4'(i), vecs[i].addr, 8'd0, vecs[i].size, vecs[i].data, 0, 0, 2'b00, 4'(i));
      chk("tbl_aw_addr", cap_aw_addr, vecs[i].exp_addr);
      chk("tbl_w_strb", 64'(cap_w_strb), 64'(vecs[i].exp_strb));
      chk("tbl_w_data", cap_w_data, vecs[i].exp_data);
      chk("tbl_w_last", 64'(cap_w_last), 64'd1);
    end

    // Burst of four with W ready toggling.
    run_txn(4'h3, 64'h8000_1000, 8'd3, 2'd3, 64'h1111_2222_3333_4444, 0, 1, 2'b00, 4'h3);
    // All W beats ahead of a late AW ready.
    run_txn(4'h5, 64'h0000_2000, 8'd3, 2'd3, 64'h5555_6666_7777_8888, 5, 0, 2'b01, 4'h5);
    chk("w_before_aw", 64'(cap_beats_at_aw), 64'd4);
    // SLVERR passes through with matching BID.
    run_txn(4'h7, 64'h0000_0100, 8'd0, 2'd3, 64'h0, 0, 0, 2'b10, 4'h7);
    // Mismatched BID: forced to SLVERR only when the ID check is built in.
    run_txn(4'h8, 64'h0000_0200, 8'd0, 2'd2, 64'h1234, 0, 0, 2'b00, 4'h9);

    // Reset in the middle of a burst.
    cpu_aw_valid = 1'b1; cpu_id = 4'h2; cpu_addr = 64'h4000; cpu_len = 8'd3; cpu_size = 2'd3;
    step();
    cpu_aw_valid = 1'b0; axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b1;
    cpu_w_valid = 1'b1; cpu_w_data = 64'hA5A5_A5A5_A5A5_A5A5;
    step(); step();
    reset = 1'b1;
    step();
    #4;
    chk("mid_rst_valids", 64'({axi_aw_valid_o, axi_w_valid_o, cpu_w_ready, axi_b_ready_o}), 64'd0);
    chk("mid_rst_aw_ready", 64'(cpu_aw_ready), 64'd1);
    chk("mid_rst_b_valid", 64'(cpu_b_valid), 64'd0);
    step();
    reset = 1'b0; cpu_w_valid = 1'b0; axi_w_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_b_valid_i = 1'b1;
      #4;
      chk("post_rst_quiet", 64'({cpu_b_valid, axi_aw_valid_o, axi_b_ready_o}), 64'd0);
      step();
    end
    axi_b_valid_i = 1'b0;
    run_txn(4'h4, 64'h0000_4000, 8'd1, 2'd3, 64'hFACE_FEED_0000_0001, 1, 0, 2'b00, 4'h4);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      r_id = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        r_len  = 8'd0;
        r_size = 2'($urandom);
        r_addr = {$urandom, $urandom};
      end else begin
        r_len  = 8'($urandom_range(1, 7));
        r_size = 2'd3;
        r_addr = {$urandom, $urandom} & ~64'h7;
      end
`ifdef YSYX_22041071_AXI_W_IDCHK_EN
      r_bid = r_id;
`else
      r_bid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : r_id;
`endif
      run_txn(r_id, r_addr, r_len, r_size, {$urandom, $urandom}, int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), 2'($urandom), r_bid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
